// File: rtl/ms_pulse_generator_if.sv
// Request/status bundle for the millisecond pulse generator.
// The master side requests timed pulses; the slave side owns the enable and its status.
interface ms_pulse_generator_if #(
  parameter int TIME_W = 19
);
  logic              start;
  logic [TIME_W-1:0] dur;
  logic              abort;
  logic              en;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [TIME_W-1:0] remaining;
  logic [TIME_W-1:0] elapsed;

  modport master (
    output start, dur, abort,
    input  en, busy, done, aborted, remaining, elapsed
  );

  modport slave (
    input  start, dur, abort,
    output en, busy, done, aborted, remaining, elapsed
  );
endinterface

// File: rtl/ms_pulse_generator.sv
// Timed-enable generator: holds en high for dur milliseconds, then reports done,
// or reports aborted when cut short. The inverse of the millisecond measurement block.
module ms_pulse_generator #(
  parameter int CLK_PER_MS = 1,
  parameter int TIME_W     = 19
) (
  input logic                 clk,
  input logic                 rst_n,
  ms_pulse_generator_if.slave bus
);

  localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [PS_W-1:0]   r_ps;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [TIME_W-1:0] r_remaining;
  logic [TIME_W-1:0] r_elapsed;

  logic              w_tick;
  logic              w_accept;

  // True when the pulse is in its final millisecond.
  function automatic logic is_last_ms(input logic [TIME_W-1:0] rem);
    return (rem == TIME_W'(1));
  endfunction

  assign w_tick   = (r_ps == PS_W'(CLK_PER_MS - 1));
  assign w_accept = bus.start & ~bus.abort;

  // Pulse sequencing: accept in IDLE, count milliseconds in RUN, end on expiry or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ps        <= {PS_W{1'b0}};
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_remaining <= {TIME_W{1'b0}};
      r_elapsed   <= {TIME_W{1'b0}};
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_elapsed <= {TIME_W{1'b0}};
            if (bus.dur != {TIME_W{1'b0}}) begin
              r_state     <= ST_RUN;
              r_en        <= 1'b1;
              r_busy      <= 1'b1;
              r_remaining <= bus.dur;
              r_ps        <= {PS_W{1'b0}};
            end else begin
              // Zero-length request completes immediately without raising en.
              r_done <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            // Abort outranks a coincident tick, so elapsed is left untouched.
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= {TIME_W{1'b0}};
            r_ps        <= {PS_W{1'b0}};
            r_aborted   <= 1'b1;
          end else if (w_tick) begin
            r_ps      <= {PS_W{1'b0}};
            r_elapsed <= r_elapsed + TIME_W'(1);
            if (is_last_ms(r_remaining)) begin
              r_state     <= ST_IDLE;
              r_en        <= 1'b0;
              r_busy      <= 1'b0;
              r_remaining <= {TIME_W{1'b0}};
              r_done      <= 1'b1;
            end else begin
              r_remaining <= r_remaining - TIME_W'(1);
            end
          end else begin
            r_ps <= r_ps + PS_W'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_en        <= 1'b0;
          r_busy      <= 1'b0;
          r_remaining <= {TIME_W{1'b0}};
          r_ps        <= {PS_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.en        = r_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.remaining = r_remaining;
  assign bus.elapsed   = r_elapsed;

endmodule

// File: doc/ms_pulse_generator.md
Name: ms_pulse_generator

Overview:
- Timed-enable generator for the train controller; inverse of the millisecond measurement block.
- Takes a duration in ms and drives an enable output high for exactly that many ms, then reports completion.
- Drives timed actuations such as motor run, barrier and signal hold windows. Its output can loop back into the measurement block for self-check.

Parameters:
- CLK_PER_MS, 1, clk cycles per millisecond tick (1 = clk is 1 kHz); must be >= 1.
- TIME_W, 19, width of duration/elapsed values in ms.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a timed pulse; sampled only in IDLE.
- dur  input  TIME_W  requested duration in ms; latched when start is accepted.
- abort  input  1  terminate a running pulse early.
- en  output  1  timed enable; high while RUN.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort completion.
- remaining  output  TIME_W  ms left in current pulse; 0 in IDLE.
- elapsed  output  TIME_W  whole ms completed by the last pulse; held until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; en, busy, done and aborted are 0.
  - remaining, elapsed and the prescaler are 0.
  - Reset mid-pulse kills en immediately, with no done/aborted pulse.
- Registered outputs: all outputs change only on rising clk, except under async reset.
- States: IDLE, RUN.
- IDLE, start=1, abort=0, dur>0:
  - Next edge: state=RUN; en=busy=1; remaining=dur; elapsed=0; prescaler=0.
- IDLE, start=1, abort=0, dur=0:
  - Stays IDLE; en stays 0.
  - done=1 for one cycle; elapsed=0.
- IDLE, start=1, abort=1: abort wins and the request is dropped, with no outputs changed.
- Prescaler (RUN):
  - Counts 0..CLK_PER_MS-1.
  - A tick occurs in the cycle the prescaler = CLK_PER_MS-1; it then wraps to 0.
  - With CLK_PER_MS=1, every RUN cycle is a tick.
- RUN, tick, remaining>1: remaining decrements; elapsed increments.
- RUN, tick, remaining=1 (and no abort):
  - Next edge: state=IDLE; en=busy=0; remaining=0; elapsed=dur.
  - done=1 for that one cycle.
- Pulse length: en is high for exactly dur*CLK_PER_MS clk cycles.
- RUN, abort=1 (takes priority over a coincident tick):
  - Next edge: state=IDLE; en=busy=0; remaining=0; aborted=1 for one cycle.
  - elapsed keeps its pre-abort value, i.e. the tick in the abort cycle is not counted.
- Start in RUN: ignored; the latched duration is not changed. dur changes during RUN are also ignored.
- Back-to-back:
  - The done cycle is an IDLE cycle, so a start asserted there is accepted.
  - en then drops for exactly one cycle between pulses.
- Arithmetic: unsigned TIME_W. The maximum dur = 2^TIME_W-1 is legal, with no wrap because remaining only counts down to 0.
- done and aborted are never high in the same cycle.

Test Plan:
- CLK_PER_MS=4, start with dur=3 → en high exactly 12 cycles; remaining steps 3,2,1 then 0; done pulses once; elapsed=3.
- dur=0 start → en never rises; done=1 for one cycle; elapsed=0; busy stays 0.
- dur=5, abort asserted on the cycle of the 3rd tick → en falls next edge; aborted=1 one cycle; done stays 0; elapsed=2.
- start held high across done → second pulse begins; en low exactly 1 cycle between pulses; second dur latched correctly.
- rst_n pulled low mid-RUN (asynchronous, between edges) → en, busy and remaining go to 0 immediately; no done; after release, start works normally.
- Loopback: en feeds the measurement block with CLK_PER_MS=1 and dur=1000 → measured 1000 ms; start during RUN with a different dur is ignored.
